vector_control_fsm: RTL and testbench
=====================================

// Module: vector_control_fsm
// PURPOSE
//  Multi-cycle successor of the single-cycle control unit for the vector core.
//  Accepts one decoded instruction per valid/ready handshake and sequences it over LANES elements, LANES_PER_CYCLE per beat.
//  Holds the NZCV flag register and evaluates branch conditions.
//  Drives datapath control, lane index and a req/ack memory handshake.
//  Sits between the instruction fetch stage and the datapath/vector register file.
// PARAMETERS
//  LANES            8   vector elements per vector register (power of 2, >=2)
//  LANES_PER_CYCLE  2   elements processed per beat (power of 2, divides LANES)
//  LANE_IDX_W       $clog2(LANES)  width of lane_idx (derived, localparam)
// PORTS
//  clk         in   1   single clock, rising edge
//  rst         in   1   synchronous, active-high reset
//  instr_valid in   1   Opcode/V/Funct/Rd valid
//  instr_ready out  1   FSM can accept an instruction (IDLE only)
//  Opcode      in   3   000 ALU-reg, 001 ALU-imm, 010 LOAD, 011 STORE, 100 BRANCH, 101 CMP, others illegal
//  V           in   1   1 = vector op, 0 = scalar
//  Funct       in   3   ALU op (ALU-*); condition for BRANCH: 000 AL, 001 EQ, 010 NE, 011 LT, 100 GE
//  Rd          in   4   destination register; 15 = PC
//  ALUFlags    in   4   {N,Z,C,Vf} from ALU, current beat
//  mem_ack     in   1   memory completes the current beat
//  mem_req     out  1   memory access request
//  PCSrc       out  1   PC takes ALU result this cycle
//  MemtoReg    out  1   write-back selects memory data
//  MemWrite    out  1   store strobe
//  ALUControl  out  3   ALU op
//  ALUSrc      out  1   1 = immediate operand
//  ImmSrc      out  2   00 ALU-imm, 01 mem offset, 10 branch offset
//  RegWrite    out  1   register-file write strobe for the current beat
//  lane_idx    out  LANE_IDX_W  first lane of the current beat
//  flags       out  4   architectural NZCV register
//  busy        out  1   instruction in flight
//  done        out  1   one-cycle pulse on the final beat
//  illegal     out  1   one-cycle pulse when an illegal opcode retires
// BEHAVIOUR
//  Reset: state IDLE, flags=0, all outputs 0 except instr_ready=1; an in-flight op is aborted with no further strobes.
//  States: IDLE, EXEC, MEM.
//  IDLE: instr_ready=1. On instr_valid, latch the fields and set lane_idx=0.
//   LOAD/STORE go to MEM; all other opcodes go to EXEC.
//  Beats: V=1 gives LANES/LANES_PER_CYCLE beats; V=0, BRANCH and illegal opcodes give 1 beat.
//  EXEC: each cycle is one beat; lane_idx += LANES_PER_CYCLE after each non-final beat.
//   Final beat: done=1; next state IDLE (a new instruction is accepted one cycle after done).
//  MEM: mem_req=1 and held until mem_ack.
//   A beat completes only in an ack cycle; lane_idx advances only on ack.
//   STORE: MemWrite=1 while mem_req.
//   LOAD: RegWrite=1 and MemtoReg=1 only in the ack cycle.
//   mem_ack outside MEM is ignored.
//  Decode (combinational from latched fields, valid in EXEC/MEM, all 0 in IDLE):
//   ALU-reg: ALUControl=Funct, ALUSrc=0, RegWrite=1 per beat.
//   ALU-imm: as ALU-reg with ALUSrc=1, ImmSrc=00.
//   LOAD/STORE: ALUControl=000, ALUSrc=1, ImmSrc=01.
//   BRANCH: ALUControl=000, ALUSrc=1, ImmSrc=10, PCSrc=cond_pass, no RegWrite.
//   CMP: ALUControl=001, no RegWrite; flags <= ALUFlags at each beat (the last beat's value remains).
//   Illegal: no strobes, illegal=1 with done.
//  PCSrc is also 1 on any beat with RegWrite=1 and Rd==15.
//  cond_pass uses the registered flags, not ALUFlags:
//   AL=1; EQ=Z; NE=!Z; LT=N^Vf; GE=!(N^Vf); Funct 101-111 = never.
//  busy = (state!=IDLE). instr_valid while busy is ignored.
//  lane_idx wraps to 0 on return to IDLE; it never exceeds LANES-LANES_PER_CYCLE.
// TESTING
//  1. Reset mid vector ALU-reg (beat 2) -> next cycle RegWrite=0, busy=0, instr_ready=1, flags=0.
//  2. ALU-reg V=1, Funct=010, LANES=8/LPC=2 -> 4 cycles RegWrite=1, ALUControl=010, lane_idx 0,2,4,6; done on 4th.
//  3. Vector LOAD with mem_ack delayed 0,2,0,1 cycles per beat -> RegWrite/MemtoReg only in ack cycles, lane_idx 0,2,4,6, done at 4th ack.
//  4. CMP with ALUFlags=0100, then BRANCH Funct=001 -> flags=0100, PCSrc=1; BRANCH Funct=010 -> PCSrc=0.
//  5. ALU-imm V=0, Rd=15 -> single beat, RegWrite=1, PCSrc=1, ALUSrc=1, done=1.
//  6. Opcode=111 -> one beat, all strobes 0, illegal=1, done=1; instr_valid held high in that beat is not accepted.

Source files
------------

// File: rtl/vector_control_fsm.sv
// Multi-cycle vector control unit: accepts one decoded instruction per handshake,
// sequences it over LANES elements, holds NZCV and drives datapath/memory controls.
module vector_control_fsm #(
  parameter int LANES           = 8,
  parameter int LANES_PER_CYCLE = 2,
  localparam int LANE_IDX_W     = $clog2(LANES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [2:0]            Opcode,
  input  logic                  V,
  input  logic [2:0]            Funct,
  input  logic [3:0]            Rd,
  input  logic [3:0]            ALUFlags,
  input  logic                  mem_ack,
  output logic                  mem_req,
  output logic                  PCSrc,
  output logic                  MemtoReg,
  output logic                  MemWrite,
  output logic [2:0]            ALUControl,
  output logic                  ALUSrc,
  output logic [1:0]            ImmSrc,
  output logic                  RegWrite,
  output logic [LANE_IDX_W-1:0] lane_idx,
  output logic [3:0]            flags,
  output logic                  busy,
  output logic                  done,
  output logic                  illegal
);

  // state | meaning
  // IDLE  | waiting for an instruction, instr_ready=1
  // EXEC  | one beat per cycle (ALU, CMP, BRANCH, illegal)
  // MEM   | one beat per mem_ack (LOAD, STORE)
  typedef enum logic [1:0] {IDLE, EXEC, MEM} state_t;

  localparam logic [2:0] OP_ALUR   = 3'b000;
  localparam logic [2:0] OP_ALUI   = 3'b001;
  localparam logic [2:0] OP_LOAD   = 3'b010;
  localparam logic [2:0] OP_STORE  = 3'b011;
  localparam logic [2:0] OP_BRANCH = 3'b100;
  localparam logic [2:0] OP_CMP    = 3'b101;

  localparam logic [LANE_IDX_W-1:0] LANE_STEP = LANE_IDX_W'(LANES_PER_CYCLE);
  localparam logic [LANE_IDX_W-1:0] LANE_LAST = LANE_IDX_W'(LANES - LANES_PER_CYCLE);

  state_t     state;
  logic [2:0] op_q;
  logic [2:0] funct_q;
  logic [3:0] rd_q;
  logic       multi_q;

  logic beat_done;
  logic last_beat;
  logic cond_pass;

  // A beat retires every EXEC cycle, but only on the ack cycle in MEM.
  assign beat_done = (state == EXEC) || ((state == MEM) && mem_ack);
  assign last_beat = !multi_q || (lane_idx == LANE_LAST);

  // Branch conditions look at the architectural flags, never the live ALU flags.
  always_comb begin
    cond_pass = 1'b0;
    case (funct_q)
      3'b000:  cond_pass = 1'b1;
      3'b001:  cond_pass = flags[2];
      3'b010:  cond_pass = !flags[2];
      3'b011:  cond_pass = flags[3] ^ flags[0];
      3'b100:  cond_pass = !(flags[3] ^ flags[0]);
      default: cond_pass = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= 3'b000;
      funct_q  <= 3'b000;
      rd_q     <= 4'd0;
      multi_q  <= 1'b0;
      lane_idx <= '0;
      flags    <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            op_q     <= Opcode;
            funct_q  <= Funct;
            rd_q     <= Rd;
            // Branches and illegal opcodes are single-beat regardless of V.
            multi_q  <= V && (Opcode != OP_BRANCH) && (Opcode <= OP_CMP);
            lane_idx <= '0;
            state    <= ((Opcode == OP_LOAD) || (Opcode == OP_STORE)) ? MEM : EXEC;
          end
        end
        EXEC, MEM: begin
          if (beat_done) begin
            if ((state == EXEC) && (op_q == OP_CMP))
              flags <= ALUFlags;
            if (last_beat) begin
              state    <= IDLE;
              lane_idx <= '0;
            end else begin
              lane_idx <= lane_idx + LANE_STEP;
            end
          end
        end
        default: begin
          state    <= IDLE;
          lane_idx <= '0;
        end
      endcase
    end
  end

  always_comb begin
    instr_ready = (state == IDLE);
    busy        = (state != IDLE);
    done        = beat_done && last_beat;
    mem_req     = 1'b0;
    PCSrc       = 1'b0;
    MemtoReg    = 1'b0;
    MemWrite    = 1'b0;
    ALUControl  = 3'b000;
    ALUSrc      = 1'b0;
    ImmSrc      = 2'b00;
    RegWrite    = 1'b0;
    illegal     = 1'b0;
    if (state != IDLE) begin
      case (op_q)
        OP_ALUR: begin
          ALUControl = funct_q;
          RegWrite   = 1'b1;
        end
        OP_ALUI: begin
          ALUControl = funct_q;
          ALUSrc     = 1'b1;
          RegWrite   = 1'b1;
        end
        OP_LOAD: begin
          ALUSrc   = 1'b1;
          ImmSrc   = 2'b01;
          mem_req  = (state == MEM);
          RegWrite = (state == MEM) && mem_ack;
          MemtoReg = (state == MEM) && mem_ack;
        end
        OP_STORE: begin
          ALUSrc   = 1'b1;
          ImmSrc   = 2'b01;
          mem_req  = (state == MEM);
          MemWrite = (state == MEM);
        end
        OP_BRANCH: begin
          ALUSrc = 1'b1;
          ImmSrc = 2'b10;
          PCSrc  = cond_pass;
        end
        OP_CMP: begin
          ALUControl = 3'b001;
        end
        default: begin
          illegal = beat_done && last_beat;
        end
      endcase
      if (RegWrite && (rd_q == 4'd15))
        PCSrc = 1'b1;
    end
  end

endmodule

// File: tb/tb_vector_control_fsm.sv
// Directed self-checking bench for vector_control_fsm (LANES=8, LANES_PER_CYCLE=2).
module tb_vector_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] Opcode;
  logic       V;
  logic [2:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       mem_ack;
  logic       mem_req;
  logic       PCSrc;
  logic       MemtoReg;
  logic       MemWrite;
  logic [2:0] ALUControl;
  logic       ALUSrc;
  logic [1:0] ImmSrc;
  logic       RegWrite;
  logic [2:0] lane_idx;
  logic [3:0] flags;
  logic       busy;
  logic       done;
  logic       illegal;

  int checks   = 0;
  int failures = 0;

  vector_control_fsm #(.LANES(8), .LANES_PER_CYCLE(2)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .Opcode(Opcode), .V(V), .Funct(Funct), .Rd(Rd), .ALUFlags(ALUFlags),
    .mem_ack(mem_ack), .mem_req(mem_req), .PCSrc(PCSrc), .MemtoReg(MemtoReg),
    .MemWrite(MemWrite), .ALUControl(ALUControl), .ALUSrc(ALUSrc), .ImmSrc(ImmSrc),
    .RegWrite(RegWrite), .lane_idx(lane_idx), .flags(flags), .busy(busy),
    .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction for one edge; returns in the first beat's cycle.
  task automatic issue(input logic [2:0] op, input logic v, input logic [2:0] fn, input logic [3:0] rd);
    Opcode      = op;
    V           = v;
    Funct       = fn;
    Rd          = rd;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    #1;
  endtask

  int delays [4] = '{0, 2, 0, 1};

  initial begin
    rst = 1'b1; instr_valid = 1'b0; Opcode = 3'b000; V = 1'b0; Funct = 3'b000;
    Rd = 4'd0; ALUFlags = 4'b0000; mem_ack = 1'b0;
    tick(); tick();
    chk("rst_instr_ready", instr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_flags", flags, 0);
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_lane_idx", lane_idx, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    tick();

    // Give flags a non-zero value so the reset test below is meaningful.
    issue(3'b101, 1'b0, 3'b000, 4'd0);
    ALUFlags = 4'b1010;
    #1;
    chk("cmp0_done", done, 1);
    chk("cmp0_aluctl", ALUControl, 3'b001);
    chk("cmp0_regwrite", RegWrite, 0);
    tick();
    chk("cmp0_flags", flags, 4'b1010);
    ALUFlags = 4'b0000;

    // Reset in the middle of a vector ALU-reg op.
    issue(3'b000, 1'b1, 3'b010, 4'd1);
    tick();
    chk("rstmid_lane_idx", lane_idx, 2);
    chk("rstmid_regwrite_before", RegWrite, 1);
    rst = 1'b1;
    tick();
    chk("rstmid_regwrite", RegWrite, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_instr_ready", instr_ready, 1);
    chk("rstmid_flags", flags, 0);
    rst = 1'b0;
    tick();

    // Vector ALU-reg: four beats.
    issue(3'b000, 1'b1, 3'b010, 4'd2);
    for (int b = 0; b < 4; b++) begin
      chk("alur_regwrite", RegWrite, 1);
      chk("alur_aluctl", ALUControl, 3'b010);
      chk("alur_lane_idx", lane_idx, 32'(b * 2));
      chk("alur_done", done, (b == 3) ? 1 : 0);
      chk("alur_busy", busy, 1);
      tick();
    end
    chk("alur_idle_busy", busy, 0);
    chk("alur_idle_lane", lane_idx, 0);

    // Vector LOAD with staggered acks.
    issue(3'b010, 1'b1, 3'b000, 4'd4);
    for (int b = 0; b < 4; b++) begin
      for (int d = 0; d < delays[b]; d++) begin
        mem_ack = 1'b0;
        #1;
        chk("ld_wait_req", mem_req, 1);
        chk("ld_wait_regwrite", RegWrite, 0);
        chk("ld_wait_memtoreg", MemtoReg, 0);
        chk("ld_wait_lane", lane_idx, 32'(b * 2));
        chk("ld_wait_done", done, 0);
        tick();
      end
      mem_ack = 1'b1;
      #1;
      chk("ld_ack_req", mem_req, 1);
      chk("ld_ack_regwrite", RegWrite, 1);
      chk("ld_ack_memtoreg", MemtoReg, 1);
      chk("ld_ack_lane", lane_idx, 32'(b * 2));
      chk("ld_ack_immsrc", ImmSrc, 2'b01);
      chk("ld_ack_pcsrc", PCSrc, 0);
      chk("ld_ack_done", done, (b == 3) ? 1 : 0);
      tick();
      mem_ack = 1'b0;
    end
    chk("ld_idle_busy", busy, 0);
    chk("ld_idle_req", mem_req, 0);

    // Scalar STORE, one wait cycle.
    issue(3'b011, 1'b0, 3'b000, 4'd0);
    chk("st_wait_memwrite", MemWrite, 1);
    chk("st_wait_regwrite", RegWrite, 0);
    chk("st_wait_done", done, 0);
    tick();
    mem_ack = 1'b1;
    #1;
    chk("st_ack_memwrite", MemWrite, 1);
    chk("st_ack_done", done, 1);
    tick();
    mem_ack = 1'b0;
    chk("st_idle_busy", busy, 0);

    // CMP then branches evaluated on the registered flags.
    issue(3'b101, 1'b0, 3'b000, 4'd0);
    ALUFlags = 4'b0100;
    tick();
    chk("cmp_flags", flags, 4'b0100);
    ALUFlags = 4'b1000;
    issue(3'b100, 1'b0, 3'b001, 4'd0);
    chk("beq_pcsrc", PCSrc, 1);
    chk("beq_immsrc", ImmSrc, 2'b10);
    chk("beq_alusrc", ALUSrc, 1);
    chk("beq_regwrite", RegWrite, 0);
    chk("beq_done", done, 1);
    tick();
    issue(3'b100, 1'b0, 3'b010, 4'd0);
    chk("bne_pcsrc", PCSrc, 0);
    tick();
    issue(3'b100, 1'b0, 3'b100, 4'd0);
    chk("bge_pcsrc", PCSrc, 1);
    tick();
    issue(3'b100, 1'b1, 3'b011, 4'd0);
    chk("blt_pcsrc", PCSrc, 0);
    chk("blt_done", done, 1);
    tick();
    chk("branch_flags_kept", flags, 4'b0100);

    // Scalar ALU-imm writing the PC.
    issue(3'b001, 1'b0, 3'b100, 4'd15);
    chk("alui_regwrite", RegWrite, 1);
    chk("alui_pcsrc", PCSrc, 1);
    chk("alui_alusrc", ALUSrc, 1);
    chk("alui_immsrc", ImmSrc, 2'b00);
    chk("alui_aluctl", ALUControl, 3'b100);
    chk("alui_done", done, 1);
    tick();
    chk("alui_idle_busy", busy, 0);

    // Illegal opcode; instr_valid held high during its beat is ignored.
    issue(3'b111, 1'b1, 3'b000, 4'd15);
    Opcode = 3'b000; V = 1'b0; Funct = 3'b011; Rd = 4'd5;
    instr_valid = 1'b1;
    #1;
    chk("ill_illegal", illegal, 1);
    chk("ill_done", done, 1);
    chk("ill_regwrite", RegWrite, 0);
    chk("ill_memreq", mem_req, 0);
    chk("ill_memwrite", MemWrite, 0);
    chk("ill_pcsrc", PCSrc, 0);
    chk("ill_instr_ready", instr_ready, 0);
    tick();
    chk("ill_after_busy", busy, 0);
    chk("ill_after_ready", instr_ready, 1);
    chk("ill_after_illegal", illegal, 0);
    tick();
    instr_valid = 1'b0;
    chk("next_busy", busy, 1);
    chk("next_regwrite", RegWrite, 1);
    chk("next_aluctl", ALUControl, 3'b011);
    chk("next_done", done, 1);
    tick();
    chk("final_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
